// File: rtl/arb_pkg.sv
// Shared types and the rotating-priority search used by the 4-way round-robin arbiter.
package arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // First unmasked requester at or after ptr, wrapping modulo NUM_REQ.
  function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req,
                                    input logic [IDX_W-1:0]   ptr,
                                    input logic [NUM_REQ-1:0] mask);
    pick_t              res;
    logic [NUM_REQ-1:0] cand;
    logic [IDX_W-1:0]   idx;
    res.found = 1'b0;
    res.idx   = {IDX_W{1'b0}};
    cand      = req & ~mask;
    // Walk from the farthest offset down so the nearest candidate wins last.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ptr + IDX_W'(k);
      if (cand[idx]) begin
        res.found = 1'b1;
        res.idx   = idx;
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/dec2to4.sv
// 2-to-4 one-hot decoder with enable; drives the shared-resource select lines.
module dec2to4
  import arb_pkg::*;
(
  input  logic [IDX_W-1:0]   idx,
  input  logic               en,
  output logic [NUM_REQ-1:0] onehot
);

  // Decode the index, forcing all-zero when disabled.
  always_comb begin
    onehot = 4'b0000;
    if (en) begin
      case (idx)
        2'd0:    onehot = 4'b0001;
        2'd1:    onehot = 4'b0010;
        2'd2:    onehot = 4'b0100;
        2'd3:    onehot = 4'b1000;
        default: onehot = 4'b0000;
      endcase
    end else begin
      onehot = 4'b0000;
    end
  end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with an optional per-grant hold limit.
module rr_arbiter4
  import arb_pkg::*;
#(
  parameter int HOLD_MAX = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid,
  output logic               timeout
);

  localparam int CNT_W = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(HOLD_MAX);

  arb_state_t         state_r;
  logic [IDX_W-1:0]   ptr_r;
  logic [IDX_W-1:0]   idx_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               timeout_r;

  pick_t              idle_pick_s;
  pick_t              hand_pick_s;
  logic [IDX_W-1:0]   hand_ptr_s;
  logic [NUM_REQ-1:0] own_mask_s;
  logic               keep_s;

  // Candidate winners for a fresh grant from IDLE and for a handoff away from the grantee.
  always_comb begin
    hand_ptr_s  = idx_r + 2'd1;
    own_mask_s  = 4'b0001 << idx_r;
    idle_pick_s = rr_pick(req, ptr_r, 4'b0000);
    hand_pick_s = rr_pick(req, hand_ptr_s, own_mask_s);
    if (HOLD_MAX == 0) begin
      keep_s = req[idx_r];
    end else begin
      keep_s = req[idx_r] && (cnt_r < CNT_LIM);
    end
  end

  // Arbitration state machine; a dropped request and an expired hold share one handoff path.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      ptr_r     <= 2'd0;
      idx_r     <= 2'd0;
      cnt_r     <= {CNT_W{1'b0}};
      timeout_r <= 1'b0;
    end else begin
      timeout_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (idle_pick_s.found) begin
            state_r <= GRANT;
            idx_r   <= idle_pick_s.idx;
            cnt_r   <= CNT_ONE;
          end else begin
            state_r <= IDLE;
          end
        end
        GRANT: begin
          if (keep_s) begin
            if (cnt_r != CNT_SAT) begin
              cnt_r <= cnt_r + CNT_ONE;
            end else begin
              cnt_r <= cnt_r;
            end
          end else begin
            ptr_r     <= hand_ptr_s;
            timeout_r <= req[idx_r];
            if (hand_pick_s.found) begin
              state_r <= GRANT;
              idx_r   <= hand_pick_s.idx;
              cnt_r   <= CNT_ONE;
            end else begin
              state_r <= IDLE;
              cnt_r   <= {CNT_W{1'b0}};
            end
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  assign grant_valid = (state_r == GRANT);
  assign grant_idx   = idx_r;
  assign timeout     = timeout_r;

  dec2to4 u_dec (
    .idx    (idx_r),
    .en     (grant_valid),
    .onehot (grant)
  );

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4: one unlimited-hold instance and one with HOLD_MAX=4.
module tb_rr_arbiter4;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req0, req4;
  logic [3:0] grant0, grant4;
  logic [1:0] idx0, idx4;
  logic       valid0, valid4, to0, to4;
  int         tests = 0;
  int         fails = 0;

  always #5 clk = ~clk;

  rr_arbiter4 #(.HOLD_MAX(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req0), .grant(grant0),
    .grant_idx(idx0), .grant_valid(valid0), .timeout(to0));

  rr_arbiter4 #(.HOLD_MAX(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req(req4), .grant(grant4),
    .grant_idx(idx4), .grant_valid(valid4), .timeout(to4));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Packs {grant, grant_valid, timeout} for each instance.
  function automatic logic [7:0] s0();
    return {2'b00, grant0, valid0, to0};
  endfunction
  function automatic logic [7:0] s4();
    return {2'b00, grant4, valid4, to4};
  endfunction

  initial begin
    logic [3:0] exp_g;
    rst_n = 1'b0;
    req0  = 4'b1111;
    req4  = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_dut0", s0(), {2'b00, 4'b0000, 1'b0, 1'b0});
    end
    chk("reset_dut4", s4(), {2'b00, 4'b0000, 1'b0, 1'b0});
    rst_n = 1'b1;
    tick();
    chk("first_grant", s0(), {2'b00, 4'b0001, 1'b1, 1'b0});
    chk("first_idx", {6'd0, idx0}, {6'd0, 2'd0});

    // Rotation with no bubbles: each grantee drops req for one cycle after two cycles.
    for (int k = 0; k < 4; k++) begin
      exp_g = 4'b0001 << k;
      chk("rot_c1", s0(), {2'b00, exp_g, 1'b1, 1'b0});
      tick();
      chk("rot_c2", s0(), {2'b00, exp_g, 1'b1, 1'b0});
      req0 = 4'b1111 & ~exp_g;
      tick();
      req0 = 4'b1111;
    end
    chk("rot_wrap", s0(), {2'b00, 4'b0001, 1'b1, 1'b0});

    // Move grant to requester 3, then reset mid-grant.
    req0 = 4'b1000;
    tick();
    chk("pre_rst_grant", s0(), {2'b00, 4'b1000, 1'b1, 1'b0});
    chk("pre_rst_idx", {6'd0, idx0}, {6'd0, 2'd3});
    rst_n = 1'b0;
    tick();
    chk("mid_rst", s0(), {2'b00, 4'b0000, 1'b0, 1'b0});
    rst_n = 1'b1;
    req0  = 4'b1010;
    tick();
    chk("post_rst_ptr0", s0(), {2'b00, 4'b0010, 1'b1, 1'b0});

    // No preemption of requester 2 by requesters 0 and 3.
    req0 = 4'b0100;
    tick();
    chk("np_grant2", s0(), {2'b00, 4'b0100, 1'b1, 1'b0});
    req0 = 4'b1101;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("np_hold", s0(), {2'b00, 4'b0100, 1'b1, 1'b0});
    end
    req0 = 4'b1001;
    tick();
    chk("np_handoff_ptr3", s0(), {2'b00, 4'b1000, 1'b1, 1'b0});

    // Sole requester hits the hold limit.
    req4 = 4'b0100;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("to_hold", s4(), {2'b00, 4'b0100, 1'b1, 1'b0});
      tick();
    end
    chk("to_pulse_idle", s4(), {2'b00, 4'b0000, 1'b0, 1'b1});
    tick();
    chk("to_regrant", s4(), {2'b00, 4'b0100, 1'b1, 1'b0});
    req4 = 4'b0000;
    tick();
    chk("to_release_idle", s4(), {2'b00, 4'b0000, 1'b0, 1'b0});

    // Timeout handoff between requesters 0 and 2 (ptr=3 wraps to requester 0 first).
    req4 = 4'b0101;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("toh_hold0", s4(), {2'b00, 4'b0001, 1'b1, 1'b0});
      tick();
    end
    chk("toh_to2", s4(), {2'b00, 4'b0100, 1'b1, 1'b1});
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("toh_hold2", s4(), {2'b00, 4'b0100, 1'b1, 1'b0});
    end
    tick();
    chk("toh_to0", s4(), {2'b00, 4'b0001, 1'b1, 1'b1});
    tick();
    chk("toh_pulse_end", s4(), {2'b00, 4'b0001, 1'b1, 1'b0});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
